imem_loader: RTL

Byte-stream program loader that writes the instruction memory the CPU fetches from, so a new program can be loaded without resynthesis. It sits between a byte source (UART receiver or debug bridge, valid/ready handshake) and the write port of the 1024-word instruction memory. While loading, it holds the CPU in reset. It releases the CPU only after a complete, well-formed image has been written.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/loader_timeout.sv | 28 ++
 rtl/imem_loader.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and
// frame geometry constants.
package loader_pkg;

  typedef enum logic [2:0] {
    S_HDR_LO,
    S_HDR_HI,
    S_PAYLOAD,
    S_CHK,
    S_FIN,
    S_DONE,
    S_ERR
  } state_t;

  // Header is the 16-bit word count, low byte first.
  localparam int HDR_LEN        = 2;
  // Payload words are big-endian, four bytes each.
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog for the loader. Counts idle cycles while enabled;
// o_expired fires on the cycle the count would reach TIMEOUT, so the owner
// leaves its state exactly TIMEOUT idle cycles after the last accepted byte.
module loader_timeout #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Idle-cycle counter; cleared by any accepted byte or while disabled, saturates.
  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_cnt <= '0;
    else if (i_en && (r_cnt != CW'(TIMEOUT)))
      r_cnt <= r_cnt + CW'(1);
  end

  assign o_expired = i_en && !i_clr && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader for the instruction memory. Parses a
// count-prefixed frame, writes big-endian words from address 0, holds the
// CPU in reset until a complete image is in memory.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte over the payload before release.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_POST = S_CHK;
`else
  localparam state_t S_POST = S_FIN;
`endif

  state_t      r_state, w_next;
  logic [7:0]  r_cnt_lo;
  logic [15:0] r_n;
  logic [15:0] r_widx;
  logic [1:0]  r_bcnt;
  logic [23:0] r_shift;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  logic        w_acc, w_expired, w_tmo_en, w_word_done, w_last_word;
  logic [15:0] w_n;

  assign w_acc       = in_valid && in_ready;
  assign w_n         = {in_data, r_cnt_lo};
  assign w_word_done = (r_bcnt == 2'(BYTES_PER_WORD - 1));
  assign w_last_word = (r_widx == r_n - 16'd1);
  assign w_tmo_en    = (r_state == S_HDR_HI) || (r_state == S_PAYLOAD) ||
                       (r_state == S_CHK);

  loader_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_acc || !w_tmo_en),
    .i_en      (w_tmo_en),
    .o_expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_HDR_LO;
    else     r_state <= w_next;
  end

  // Next-state and state-decoded outputs; in_ready depends on state only.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (r_state)
      S_HDR_LO: begin
        in_ready = 1'b1;
        if (w_acc) w_next = S_HDR_HI;
      end
      S_HDR_HI: begin
        in_ready = 1'b1;
        if (w_acc) begin
          if ({1'b0, w_n} > MAX_WORDS) w_next = S_ERR;
          else if (w_n == 16'd0)       w_next = S_POST;
          else                         w_next = S_PAYLOAD;
        end else if (w_expired) begin
          w_next = S_ERR;
        end
      end
      S_PAYLOAD: begin
        in_ready = 1'b1;
        if (w_acc) begin
          if (w_word_done && w_last_word) w_next = S_POST;
        end else if (w_expired) begin
          w_next = S_ERR;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        in_ready = 1'b1;
        if (w_acc)          w_next = (in_data == r_csum) ? S_FIN : S_ERR;
        else if (w_expired) w_next = S_ERR;
      end
`endif
      // Write issued on the way in has landed by the end of this cycle.
      S_FIN: w_next = S_DONE;
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (load_req) w_next = S_HDR_LO;
      end
      S_ERR: begin
        error = 1'b1;
        if (load_req) w_next = S_HDR_LO;
      end
      default: w_next = S_HDR_LO;
    endcase
  end

  // Frame datapath: header latch, byte assembly and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_lo   <= '0;
      r_n        <= '0;
      r_widx     <= '0;
      r_bcnt     <= '0;
      r_shift    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (r_state)
        S_HDR_LO: if (w_acc) begin
          r_cnt_lo <= in_data;
          r_widx   <= '0;
          r_bcnt   <= '0;
`ifdef LOADER_CHECKSUM_EN
          r_csum   <= '0;
`endif
        end
        S_HDR_HI: if (w_acc) r_n <= w_n;
        S_PAYLOAD: if (w_acc) begin
          r_bcnt  <= r_bcnt + 2'd1;
          r_shift <= {r_shift[15:0], in_data};
`ifdef LOADER_CHECKSUM_EN
          r_csum  <= r_csum ^ in_data;
`endif
          if (w_word_done) begin
            imem_we    <= 1'b1;
            imem_addr  <= r_widx[ADDR_W-1:0];
            imem_wdata <= {r_shift, in_data};
            r_widx     <= r_widx + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
